// File: rtl/maquina_alarma_zonas.sv
// maquina_alarma_zonas
// Multi-zone alarm controller. Each zone supplies a raw temperature flag, a
// raw smoke flag and an N-bit current reading. Flags are synchronized and
// debounced; the current is registered once. A four-state machine
// (APAGADO / NORMAL / PREVENCION / ALERTA) drives the LEDs and buzzers.
//
// Ports
//   clk, rst            clock, asynchronous active-low reset
//   interruptor         arm switch (1 = armed), synchronous
//   ack                 alert acknowledge, level, synchronous
//   temp, humo          raw per-zone flags, bit z = zone z
//   corriente           per-zone current, zone z at [z*N +: N]
//   LEDalerta/LEDprevencion/LEDnormal   state indicators
//   alarma_alerta/alarma_prevencion     buzzers (prevention one beeps)
//   hexa3               state code (0..3)
//   hexa2               captured triggering zone
//   hexa1, hexa0        alert-event count, high/low nibble
//   dbg_estado          current state register, for checkers
//
// Every output is a register and changes on the same edge as the state.
module maquina_alarma_zonas #(
  parameter int ZONES     = 4,
  parameter int N         = 4,
  parameter int LIM_PREV  = 8,
  parameter int LIM_ALERT = 12,
  parameter int DEB       = 4,
  parameter int PREV_HOLD = 16,
  parameter int BEEP      = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               interruptor,
  input  logic               ack,
  input  logic [ZONES-1:0]   temp,
  input  logic [ZONES-1:0]   humo,
  input  logic [ZONES*N-1:0] corriente,
  output logic               LEDalerta,
  output logic               LEDprevencion,
  output logic               LEDnormal,
  output logic               alarma_alerta,
  output logic               alarma_prevencion,
  output logic [3:0]         hexa3,
  output logic [3:0]         hexa2,
  output logic [3:0]         hexa1,
  output logic [3:0]         hexa0,
  output logic [1:0]         dbg_estado
);

  typedef enum logic [1:0] {
    APAGADO    = 2'd0,
    NORMAL     = 2'd1,
    PREVENCION = 2'd2,
    ALERTA     = 2'd3
  } estado_t;

  localparam int DW = $clog2(DEB + 1);
  localparam int QW = $clog2(PREV_HOLD + 1);
  localparam int BW = $clog2(BEEP + 1);

  estado_t estado, estado_sig;

  logic [ZONES*N-1:0] cor_q;
  logic [ZONES-1:0]   temp_deb, humo_deb;
  logic [ZONES-1:0]   prev_v, alert_v;
  logic               any_prev, any_alert;
  logic [3:0]         prev_idx, alert_idx;

  logic [QW-1:0] quiet_q, quiet_d;
  logic [BW-1:0] beep_cnt_q, beep_cnt_d;
  logic          beep_d;
  logic [7:0]    cont_q, cont_d;
  logic [3:0]    zona_d;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) cor_q <= '0;
    else      cor_q <= corriente;
  end

  // Per zone: 2-flop synchronizers, then a counter that must see DEB
  // consecutive samples differing from the debounced value before it flips.
  for (genvar z = 0; z < ZONES; z++) begin : g_zona
    logic          t_s1, t_s2, t_deb, h_s1, h_s2, h_deb;
    logic [DW-1:0] t_cnt, h_cnt;
    logic [N-1:0]  cor_z;

    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        t_s1 <= 1'b0; t_s2 <= 1'b0; t_deb <= 1'b0; t_cnt <= '0;
        h_s1 <= 1'b0; h_s2 <= 1'b0; h_deb <= 1'b0; h_cnt <= '0;
      end else begin
        t_s1 <= temp[z];
        t_s2 <= t_s1;
        h_s1 <= humo[z];
        h_s2 <= h_s1;
        if (t_s2 == t_deb) begin
          t_cnt <= '0;
        end else if (t_cnt == DW'(DEB - 1)) begin
          t_deb <= t_s2;
          t_cnt <= '0;
        end else begin
          t_cnt <= t_cnt + 1'b1;
        end
        if (h_s2 == h_deb) begin
          h_cnt <= '0;
        end else if (h_cnt == DW'(DEB - 1)) begin
          h_deb <= h_s2;
          h_cnt <= '0;
        end else begin
          h_cnt <= h_cnt + 1'b1;
        end
      end
    end

    assign cor_z       = cor_q[z*N +: N];
    assign temp_deb[z] = t_deb;
    assign humo_deb[z] = h_deb;
    assign prev_v[z]   = t_deb | (32'(cor_z) >= LIM_PREV);
    assign alert_v[z]  = h_deb | (t_deb & (32'(cor_z) >= LIM_ALERT));
  end

  assign any_prev  = |prev_v;
  assign any_alert = |alert_v;

  // Lowest-index active zone: scan from the top so the lowest hit wins.
  always_comb begin
    prev_idx  = '0;
    alert_idx = '0;
    for (int z = ZONES - 1; z >= 0; z--) begin
      if (prev_v[z])  prev_idx  = 4'(z);
      if (alert_v[z]) alert_idx = 4'(z);
    end
  end

  // State register plus all registered outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      estado            <= APAGADO;
      quiet_q           <= '0;
      beep_cnt_q        <= '0;
      cont_q            <= '0;
      LEDalerta         <= 1'b0;
      LEDprevencion     <= 1'b0;
      LEDnormal         <= 1'b0;
      alarma_alerta     <= 1'b0;
      alarma_prevencion <= 1'b0;
      hexa3             <= '0;
      hexa2             <= '0;
    end else begin
      estado            <= estado_sig;
      quiet_q           <= quiet_d;
      beep_cnt_q        <= beep_cnt_d;
      cont_q            <= cont_d;
      LEDalerta         <= (estado_sig == ALERTA);
      LEDprevencion     <= (estado_sig == PREVENCION);
      LEDnormal         <= (estado_sig == NORMAL);
      alarma_alerta     <= (estado_sig == ALERTA);
      alarma_prevencion <= beep_d;
      hexa3             <= {2'b00, estado_sig};
      hexa2             <= zona_d;
    end
  end

  // Next state. An alert outranks disarming; disarming outranks prevention.
  always_comb begin
    estado_sig = estado;
    case (estado)
      APAGADO: begin
        if (interruptor) estado_sig = NORMAL;
      end
      NORMAL: begin
        if (any_alert)         estado_sig = ALERTA;
        else if (!interruptor) estado_sig = APAGADO;
        else if (any_prev)     estado_sig = PREVENCION;
      end
      PREVENCION: begin
        if (any_alert)         estado_sig = ALERTA;
        else if (!interruptor) estado_sig = APAGADO;
        else if (!any_prev && quiet_q == QW'(PREV_HOLD - 1))
                               estado_sig = NORMAL;
      end
      ALERTA: begin
        if (ack && !any_alert) estado_sig = any_prev ? PREVENCION : NORMAL;
      end
      default: estado_sig = APAGADO;
    endcase
  end

  // Next values of counters, beep and captured zone.
  always_comb begin
    quiet_d    = '0;
    beep_cnt_d = '0;
    beep_d     = 1'b0;
    cont_d     = cont_q;
    zona_d     = hexa2;
    if (estado_sig != estado) begin
      case (estado_sig)
        APAGADO:    zona_d = '0;
        PREVENCION: zona_d = prev_idx;
        ALERTA:     zona_d = alert_idx;
        default:    zona_d = hexa2;
      endcase
    end
    if (estado_sig == ALERTA && estado != ALERTA && cont_q != 8'hFF)
      cont_d = cont_q + 8'd1;
    if (estado_sig == PREVENCION) begin
      if (estado != PREVENCION) begin
        beep_d = 1'b1;
      end else begin
        quiet_d = any_prev ? '0 : quiet_q + 1'b1;
        if (beep_cnt_q == BW'(BEEP - 1)) begin
          beep_d = ~alarma_prevencion;
        end else begin
          beep_d     = alarma_prevencion;
          beep_cnt_d = beep_cnt_q + 1'b1;
        end
      end
    end
  end

  assign hexa1      = cont_q[7:4];
  assign hexa0      = cont_q[3:0];
  assign dbg_estado = estado;

endmodule

// File: tb/tb_maquina_alarma_zonas.sv
// Directed bench for maquina_alarma_zonas with default parameters.
// Inputs are driven 1 time unit after a rising edge and outputs are sampled
// at the same point, i.e. away from the active edge.
// Observed vector: {LEDalerta, LEDprevencion, LEDnormal, alarma_alerta,
//                   alarma_prevencion, hexa3, hexa2, hexa1, hexa0}.
module tb_maquina_alarma_zonas;

  localparam int W = 21;

  logic        clk = 1'b0;
  logic        rst;
  logic        interruptor, ack;
  logic [3:0]  temp, humo;
  logic [15:0] corriente;
  logic        LEDalerta, LEDprevencion, LEDnormal;
  logic        alarma_alerta, alarma_prevencion;
  logic [3:0]  hexa3, hexa2, hexa1, hexa0;
  logic [1:0]  dbg_estado;
  logic [W-1:0] obs;

  int n_checks = 0;
  int n_fail   = 0;
  logic [W-1:0] exp_q[$];

  maquina_alarma_zonas dut (
    .clk(clk), .rst(rst), .interruptor(interruptor), .ack(ack),
    .temp(temp), .humo(humo), .corriente(corriente),
    .LEDalerta(LEDalerta), .LEDprevencion(LEDprevencion), .LEDnormal(LEDnormal),
    .alarma_alerta(alarma_alerta), .alarma_prevencion(alarma_prevencion),
    .hexa3(hexa3), .hexa2(hexa2), .hexa1(hexa1), .hexa0(hexa0),
    .dbg_estado(dbg_estado)
  );

  // Clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
    $fatal(1);
  end

  assign obs = {LEDalerta, LEDprevencion, LEDnormal, alarma_alerta,
                alarma_prevencion, hexa3, hexa2, hexa1, hexa0};

  typedef struct {
    logic         intr;
    logic         ack;
    logic [3:0]   temp;
    logic [3:0]   humo;
    logic [15:0]  cor;
    int           cyc;
    logic [W-1:0] exp;
  } vec_t;

  vec_t tbl[0:20];

  // Driver tasks
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic i, input logic a, input logic [3:0] t,
                       input logic [3:0] h, input logic [15:0] c);
    interruptor = i;
    ack         = a;
    temp        = t;
    humo        = h;
    corriente   = c;
  endtask

  // Scoreboard: expected values are queued, then popped against the DUT.
  task automatic check_obs(input string name);
    logic [W-1:0] e;
    e = exp_q.pop_front();
    n_checks++;
    if (obs !== e) begin
      n_fail++;
      $display("FAIL %s: got %h required %h", name, obs, e);
    end
  endtask

  task automatic check_val(input string name, input logic [7:0] got,
                           input logic [7:0] req);
    n_checks++;
    if (got !== req) begin
      n_fail++;
      $display("FAIL %s: got %h required %h", name, got, req);
    end
  endtask

  task automatic wait_led(input bit want_alerta, output bit ok);
    ok = 1'b0;
    for (int k = 0; k < 20; k++) begin
      step(1);
      if (want_alerta ? LEDalerta : LEDnormal) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  initial begin
    bit ok;
    logic [7:0] exp_cnt;

    //            intr ack temp  humo  cor        cyc  {leds, h3 h2 h1 h0}
    tbl[0]  = '{1'b1, 1'b0, 4'h0, 4'h0, 16'h0000, 1,  {5'b00100, 16'h1000}};
    tbl[1]  = '{1'b1, 1'b0, 4'h0, 4'h0, 16'h0900, 1,  {5'b00100, 16'h1000}};
    tbl[2]  = '{1'b1, 1'b0, 4'h0, 4'h0, 16'h0900, 1,  {5'b01001, 16'h2200}};
    tbl[3]  = '{1'b1, 1'b0, 4'h0, 4'h0, 16'h0900, 7,  {5'b01001, 16'h2200}};
    tbl[4]  = '{1'b1, 1'b0, 4'h0, 4'h0, 16'h0900, 1,  {5'b01000, 16'h2200}};
    tbl[5]  = '{1'b1, 1'b0, 4'h0, 4'h0, 16'h0900, 7,  {5'b01000, 16'h2200}};
    tbl[6]  = '{1'b1, 1'b0, 4'h0, 4'h0, 16'h0900, 1,  {5'b01001, 16'h2200}};
    tbl[7]  = '{1'b1, 1'b0, 4'h0, 4'h0, 16'h0000, 16, {5'b01001, 16'h2200}};
    tbl[8]  = '{1'b1, 1'b0, 4'h0, 4'h0, 16'h0000, 1,  {5'b00100, 16'h1200}};
    tbl[9]  = '{1'b1, 1'b0, 4'h0, 4'h2, 16'h0000, 3,  {5'b00100, 16'h1200}};
    tbl[10] = '{1'b1, 1'b0, 4'h0, 4'h0, 16'h0000, 6,  {5'b00100, 16'h1200}};
    tbl[11] = '{1'b1, 1'b0, 4'h0, 4'h2, 16'h0000, 6,  {5'b00100, 16'h1200}};
    tbl[12] = '{1'b1, 1'b0, 4'h0, 4'h2, 16'h0000, 1,  {5'b10010, 16'h3101}};
    tbl[13] = '{1'b0, 1'b1, 4'h0, 4'h2, 16'h0000, 3,  {5'b10010, 16'h3101}};
    tbl[14] = '{1'b0, 1'b0, 4'h0, 4'h0, 16'h0000, 6,  {5'b10010, 16'h3101}};
    tbl[15] = '{1'b1, 1'b1, 4'h0, 4'h0, 16'h0000, 1,  {5'b00100, 16'h1101}};
    tbl[16] = '{1'b0, 1'b0, 4'h0, 4'h0, 16'h0000, 1,  {5'b00000, 16'h0001}};
    tbl[17] = '{1'b1, 1'b0, 4'h0, 4'h0, 16'h0000, 1,  {5'b00100, 16'h1001}};
    tbl[18] = '{1'b1, 1'b0, 4'h1, 4'h8, 16'h000D, 2,  {5'b01001, 16'h2001}};
    tbl[19] = '{1'b1, 1'b0, 4'h1, 4'h8, 16'h000D, 5,  {5'b10010, 16'h3002}};
    tbl[20] = '{1'b1, 1'b1, 4'h0, 4'h0, 16'h0000, 8,  {5'b00100, 16'h1002}};

    // Reset
    rst = 1'b0;
    drive(1'b0, 1'b0, 4'h0, 4'h0, 16'h0000);
    step(3);
    exp_q.push_back('0);
    check_obs("reset_state");
    rst = 1'b1;

    // Table-driven main sequence
    for (int i = 0; i < 21; i++) begin
      drive(tbl[i].intr, tbl[i].ack, tbl[i].temp, tbl[i].humo, tbl[i].cor);
      step(tbl[i].cyc);
      exp_q.push_back(tbl[i].exp);
      check_obs($sformatf("vec_%0d", i));
    end

    // Event counter saturation: repeated alert / acknowledge rounds
    drive(1'b1, 1'b0, 4'h0, 4'h0, 16'h0000);
    exp_cnt = 8'h02;
    for (int r = 0; r < 260; r++) begin
      humo = 4'h1;
      ack  = 1'b0;
      wait_led(1'b1, ok);
      check_val($sformatf("alert_entry_%0d", r), {7'd0, ok}, 8'h01);
      if (!ok) break;
      exp_cnt = (exp_cnt == 8'hFF) ? 8'hFF : exp_cnt + 8'd1;
      check_val($sformatf("count_%0d", r), {hexa1, hexa0}, exp_cnt);
      humo = 4'h0;
      ack  = 1'b1;
      wait_led(1'b0, ok);
      check_val($sformatf("ack_exit_%0d", r), {7'd0, ok}, 8'h01);
      if (!ok) break;
    end
    ack = 1'b0;
    check_val("count_saturated", {hexa1, hexa0}, 8'hFF);

    // Asynchronous reset in the middle of ALERTA
    humo = 4'h1;
    wait_led(1'b1, ok);
    check_val("alert_before_reset", {7'd0, ok}, 8'h01);
    rst = 1'b0;
    #1;
    exp_q.push_back('0);
    check_obs("async_reset_outputs");
    drive(1'b1, 1'b0, 4'h0, 4'h0, 16'h0000);
    step(1);
    rst = 1'b1;
    step(1);
    exp_q.push_back({5'b00100, 16'h1000});
    check_obs("rearm_after_reset");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/maquina_alarma_zonas.md
# maquina_alarma_zonas

Multi-zone successor to the single-zone alarm state machine: monitors ZONES independent zones, each with a temperature flag, a smoke flag and an N-bit current reading, and drives the global alarm LEDs and buzzers. Each flag is debounced, alert states latch until acknowledged, and the triggering zone and an alert-event count are reported. The four hex digits feed the existing 4-digit seven-segment time multiplexer unchanged.

## Interface
- ZONES, 4, number of monitored zones (1..16)
- N, 4, current reading width per zone
- LIM_PREV, 8, current threshold for prevention (compare: corriente_z >= LIM_PREV)
- LIM_ALERT, 12, current threshold that, combined with temp, raises alert
- DEB, 4, debounce length in cycles for temp/humo (>=1)
- PREV_HOLD, 16, consecutive quiet cycles needed to leave PREVENCION
- BEEP, 8, half-period in cycles of the alarma_prevencion beep
- clk  in  1  system clock, all state on rising edge
- rst  in  1  asynchronous, active-low reset
- interruptor  in  1  arm switch (1 = armed)
- ack  in  1  alert acknowledge, level sampled each cycle
- temp  in  ZONES  raw temperature flags, bit z = zone z
- humo  in  ZONES  raw smoke flags
- corriente  in  ZONES*N  current readings, zone z at [z*N +: N]
- LEDalerta, LEDprevencion, LEDnormal  out  1 each  state indicators
- alarma_alerta, alarma_prevencion  out  1 each  buzzers
- hexa3, hexa2, hexa1, hexa0  out  4 each  display digits

## Operation
- temp/humo: 2-flop synchronizer per bit, then per-bit debounce counter; debounced bit changes only after DEB consecutive synchronized samples at the new value (symmetric rise/fall).
- corriente: registered once, not debounced.
- Per zone: prev_z = temp_deb_z | (cor_z >= LIM_PREV); alert_z = humo_deb_z | (temp_deb_z & cor_z >= LIM_ALERT). Unsigned compares.
- States (hexa3 code): APAGADO 0, NORMAL 1, PREVENCION 2, ALERTA 3.
- APAGADO: interruptor=1 -> NORMAL.
- NORMAL: any alert_z -> ALERTA; else any prev_z -> PREVENCION; interruptor=0 -> APAGADO (lowest priority... interruptor=0 wins over NORMAL/PREVENCION transitions).
- PREVENCION: any alert_z -> ALERTA; quiet counter counts cycles with no prev_z, resets to 0 on any prev_z; reaching PREV_HOLD -> NORMAL; interruptor=0 -> APAGADO.
- ALERTA: latched; interruptor ignored. ack=1 with no alert_z -> PREVENCION if any prev_z else NORMAL. ack while any alert_z active is ignored.
- Zone capture: on each entry to PREVENCION or ALERTA, hexa2 <= lowest-index zone with the triggering condition; held otherwise; cleared to 0 on entry to APAGADO.
- Event counter: 8-bit, +1 on each entry to ALERTA, saturates at 0xFF, cleared only by reset. hexa1 = count[7:4], hexa0 = count[3:0].
- Moore outputs: LEDnormal in NORMAL; LEDprevencion in PREVENCION; LEDalerta and alarma_alerta in ALERTA; all off in APAGADO.
- alarma_prevencion: in PREVENCION only; high on entry, toggles every BEEP cycles; beep counter restarts on every entry.

## Timing
- Reset: state APAGADO, all LEDs/buzzers 0, hexa3..hexa0 = 0, synchronizers, debounce and quiet counters 0.
- All outputs registered; update on the same edge as the state register.
- Raw temp/humo change to state change: DEB+3 edges (2 sync, DEB debounce, 1 state).
- corriente change to state change: 2 edges.
- interruptor and ack are assumed synchronous; interruptor 1 -> NORMAL on next edge.
- Simultaneous prev and alert conditions: ALERTA wins. Alert in multiple zones: lowest index captured.
- rst asserted mid-operation: immediate return to reset values, including event counter.

## Test plan
- Defaults; reset, interruptor=1 -> hexa3=1, LEDnormal=1 one edge later; all others 0.
- corriente zone 2 = 9 -> PREVENCION after 2 edges, hexa2=2, alarma_prevencion high 8 cycles, low 8; set 0 -> NORMAL after 16 quiet cycles.
- humo[1] pulse 3 cycles -> no change; held 4+ cycles -> ALERTA at edge 7, hexa2=1, count=01.
- In ALERTA: interruptor=0 and ack with humo still high -> stays ALERTA; humo low, debounce done, ack=1 -> NORMAL.
- humo[3] and temp[0]+corriente0=13 rise together -> ALERTA, hexa2=0.
- 256 alert/ack cycles -> hexa1:hexa0 = FF, saturated; rst low mid-ALERTA -> all outputs 0 immediately.
